// File: rtl/mse_error_stage.sv
// Squared-error loss stage: per-element error (target - prediction) and summed squared loss.
// Optional ReLU-derivative gating of the error when MSE_ERROR_STAGE_RELU_DERIV_EN is defined.
module mse_error_stage #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned OUTPUT_DIM = 4,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     prediction   [OUTPUT_DIM],
  input  logic signed [WIDTH-1:0]     target       [OUTPUT_DIM],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH-1:0]     output_error [OUTPUT_DIM],
  output logic signed [ACC_WIDTH-1:0] loss
);

  localparam int unsigned IdxW = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1;
  localparam int unsigned SqW  = 2 * WIDTH;
  localparam int unsigned SumW = ((ACC_WIDTH > SqW) ? ACC_WIDTH : SqW) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OUTPUT_DIM - 1);
  localparam logic signed [SumW-1:0] AccMax = $signed(SumW'({1'b0, {(ACC_WIDTH-1){1'b1}}}));

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_t;

  state_t state_q, state_d;
  logic [IdxW-1:0] index_q;
  logic signed [WIDTH-1:0] pred_q [OUTPUT_DIM];
  logic signed [WIDTH-1:0] targ_q [OUTPUT_DIM];
  logic signed [WIDTH-1:0] err_q  [OUTPUT_DIM];
  logic signed [ACC_WIDTH-1:0] acc_q, loss_q;

  logic signed [WIDTH-1:0]     cur_pred, cur_targ, err_sat, err_gated;
  logic signed [WIDTH:0]       diff;
  logic signed [SqW-1:0]       square, square_shr;
  logic signed [SumW-1:0]      sum_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        last_elem;

  // Element datapath: only the registered copies feed it, so busy-time input changes are ignored.
  always_comb begin
    cur_pred = pred_q[index_q];
    cur_targ = targ_q[index_q];
    diff     = (WIDTH+1)'(cur_targ) - (WIDTH+1)'(cur_pred);
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      err_sat = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      err_sat = diff[WIDTH-1:0];
    end
`ifdef MSE_ERROR_STAGE_RELU_DERIV_EN
    err_gated = (cur_pred > 0) ? err_sat : '0;
`else
    err_gated = err_sat;
`endif
    square     = SqW'(err_gated) * SqW'(err_gated);
    square_shr = square >>> FRAC_BITS;
    // Both addends are non-negative, so only the upper bound needs clamping.
    sum_ext    = SumW'(acc_q) + SumW'(square_shr);
    acc_next   = (sum_ext > AccMax) ? AccMax[ACC_WIDTH-1:0] : sum_ext[ACC_WIDTH-1:0];
    last_elem  = (index_q == LastIdx);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (in_valid) state_d = StCompute;
      StCompute: if (last_elem) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      acc_q   <= '0;
      loss_q  <= '0;
      for (int i = 0; i < int'(OUTPUT_DIM); i++) begin
        pred_q[i] <= '0;
        targ_q[i] <= '0;
        err_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            pred_q  <= prediction;
            targ_q  <= target;
            acc_q   <= '0;
            index_q <= '0;
          end
        end
        StCompute: begin
          err_q[index_q] <= err_gated;
          acc_q          <= acc_next;
          if (last_elem) begin
            loss_q <= acc_next;
          end else begin
            index_q <= index_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign output_error = err_q;
  assign loss         = loss_q;

endmodule

// File: doc/mse_error_stage.md
Name: mse_error_stage

Overview:
- Loss/error stage directly downstream of fully_connected_layer.
- Consumes the layer's output_data vector plus a target vector. Produces the output_error vector that fully_connected_layer takes back as its output_error input, plus a scalar summed squared-error loss for monitoring.
- Processes one element per cycle through a small FSM, with valid/ready handshakes on both sides.
- Error sign convention: error = target - prediction. This matches the layer's additive update (w += LEARNING_RATE*err*x).

Parameters:
- WIDTH, 16: signed fixed-point width of predictions, targets and errors.
- FRAC_BITS, 8: fractional bits of the fixed-point format (Q7.8 at default).
- OUTPUT_DIM, 4: vector length; must equal the upstream layer's OUTPUT_DIM; >= 1.
- ACC_WIDTH, 32: signed width of the loss accumulator and loss output.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  prediction/target vectors valid
- in_ready  out  1  stage can accept a new vector pair
- prediction  in  signed [WIDTH-1:0] x [OUTPUT_DIM]  upstream output_data
- target  in  signed [WIDTH-1:0] x [OUTPUT_DIM]  training label
- out_valid  out  1  output_error and loss valid
- out_ready  in  1  consumer accepts results
- output_error  out  signed [WIDTH-1:0] x [OUTPUT_DIM]  per-element error to the layer
- loss  out  signed [ACC_WIDTH-1:0]  sum of squared errors, Q format with FRAC_BITS

Behaviour:
- One clock domain. reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, index = 0
  - in_ready = 1, out_valid = 0
  - output_error all 0, loss = 0, internal prediction/target copies 0
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, register both vectors, clear the accumulator, set index = 0, go to COMPUTE.
  - in_valid=0 leaves the stage idle.
- COMPUTE:
  - in_ready = 0, out_valid = 0.
  - Each edge processes element [index] from the registered copies only; input ports are ignored while busy.
  - Error: d = target - prediction at WIDTH+1 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], written to output_error[index].
  - Square: e*e at 2*WIDTH bits, arithmetic shift right by FRAC_BITS, added to the accumulator with saturation at 2^(ACC_WIDTH-1)-1. The accumulator never goes negative.
  - After element OUTPUT_DIM-1, load loss from the accumulator and go to DONE.
- DONE:
  - out_valid = 1; output_error and loss are held stable.
  - in_ready = 0; a new vector is accepted only after returning to IDLE.
  - On an edge with out_ready=1, go to IDLE. out_valid drops and in_ready rises on that same edge.
- Latency:
  - out_valid rises exactly OUTPUT_DIM edges after the accepting edge.
  - Throughput is one vector pair per OUTPUT_DIM+2 cycles when out_ready is held high.
- output_error entries may update element-by-element during COMPUTE. Consumers use them only while out_valid=1.
- Reset mid-operation (COMPUTE or DONE) aborts the current vector: next state IDLE, all outputs at reset values, no partial result is ever flagged valid.
- in_valid asserted while busy is not accepted. Upstream holds its data until in_ready && in_valid.
- OUTPUT_DIM=1: COMPUTE lasts exactly one cycle.

Optional Feature:
- Macro: MSE_ERROR_STAGE_RELU_DERIV_EN
- Defined:
  - Errors are gated by the ReLU derivative of the prediction: output_error[i] = 0 when prediction[i] <= 0, otherwise the saturated difference.
  - The squared term uses the gated error, so a gated element contributes 0 to loss.
  - Timing and FSM are unchanged.
- Undefined: no gating; every element uses the plain saturated difference.

Test Plan:
All scenarios use WIDTH=16, FRAC_BITS=8, OUTPUT_DIM=4.
1. Basic, macro undefined: prediction {256,512,-256,0}, target {512,512,0,256}, out_ready=1 -> output_error {256,0,256,256}, loss 768. out_valid exactly 4 edges after accept, high for 1 cycle.
2. Saturation: prediction[0]=-32768, target[0]=32767, other elements equal -> output_error[0]=32767, loss 4194048. Reverse the operands (prediction[0]=32767, target[0]=-32768) -> output_error[0]=-32768.
3. Backpressure: scenario 1 with out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 and a new in_valid is ignored throughout. out_ready=1 -> IDLE next edge, in_ready=1.
4. Reset mid-COMPUTE: assert reset 2 edges after accept -> next edge in_ready=1, out_valid=0, loss=0, output_error all 0. A fresh vector then completes normally with a correct loss.
5. Back-to-back: two vector pairs offered with out_ready tied high -> second accepted exactly 6 cycles after the first, each loss correct, no state carried over from the first.
6. With MSE_ERROR_STAGE_RELU_DERIV_EN defined: scenario 1 stimulus -> output_error {256,0,0,0}, loss 256.
